// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM for a shared-memory datapath with a memory-wait watchdog.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes/functs trap into HALT instead of running as nop/addu.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWr,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWr,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUctr,
  output logic       ExtOp,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       mem_err,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_RWB      = 4'd3,
    S_EXEC_I   = 4'd4,
    S_IWB      = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_LWB      = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_wait;
  logic            w_abort;
  logic            w_op_known;
  logic [2:0]      w_rctr;

  assign w_wait  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Abort fires on the cycle the counter reaches the limit, whatever mem_ready says.
  assign w_abort = (MEM_WAIT_MAX != 0) && w_wait && (r_cnt == CNT_MAX);

  assign w_op_known = (OP == OP_R) || (OP == OP_LW) || (OP == OP_SW) || (OP == OP_BEQ) ||
                      (OP == OP_J) || (OP == OP_ORI) || (OP == OP_ADDIU);

`ifdef ILLEGAL_TRAP_EN
  logic w_func_ok;
  assign w_func_ok = (func == 6'b100001) || (func == 6'b100000) || (func == 6'b100011) ||
                     (func == 6'b100010) || (func == 6'b101011) || (func == 6'b101010);
`endif

  always_comb begin
    w_rctr = 3'b000;
    case (func)
      6'b100000: w_rctr = 3'b001;
      6'b100011: w_rctr = 3'b100;
      6'b100010: w_rctr = 3'b101;
      6'b101011: w_rctr = 3'b110;
      6'b101010: w_rctr = 3'b111;
      default:   w_rctr = 3'b000;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_abort)        w_next = S_FETCH;
        else if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_op_known) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end else begin
          case (OP)
            OP_R:            w_next = S_EXEC_R;
            OP_LW, OP_SW:    w_next = S_MEM_ADDR;
            OP_BEQ:          w_next = S_BRANCH;
            OP_J:            w_next = S_JUMP;
            default:         w_next = S_EXEC_I;
          endcase
        end
      end
`ifdef ILLEGAL_TRAP_EN
      S_EXEC_R:   w_next = w_func_ok ? S_RWB : S_HALT;
      S_HALT:     w_next = S_HALT;
`else
      S_EXEC_R:   w_next = S_RWB;
`endif
      S_EXEC_I:   w_next = S_IWB;
      S_MEM_ADDR: w_next = (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (w_abort)        w_next = S_FETCH;
        else if (mem_ready) w_next = S_LWB;
      end
      S_MEM_WR: begin
        if (w_abort || mem_ready) w_next = S_FETCH;
      end
      default:    w_next = S_FETCH;
    endcase
  end

  // Counter restarts whenever the state changes or an abort re-enters FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_abort)
        r_cnt <= '0;
      else if (w_wait && !mem_ready && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    PCWr = 1'b0; IorD = 1'b0; MemRd = 1'b0; MemWr = 1'b0; IRWr = 1'b0;
    RegDst = 1'b0; MemtoReg = 1'b0; RegWr = 1'b0; ALUsrcA = 1'b0;
    ALUsrcB = 2'b00; ALUctr = 3'b000; ExtOp = 1'b0; PCSrc = 2'b00;
    instr_done = 1'b0; mem_err = 1'b0; illegal = 1'b0; state = 4'd0;
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          MemRd   = 1'b1;
          ALUsrcB = 2'b01;
          IRWr    = mem_ready && !w_abort;
          PCWr    = mem_ready && !w_abort;
          mem_err = w_abort;
        end
        S_DECODE: begin
          ALUsrcB = 2'b11;
          ExtOp   = 1'b1;
`ifndef ILLEGAL_TRAP_EN
          instr_done = !w_op_known;
`endif
        end
        S_EXEC_R: begin
          ALUsrcA = 1'b1;
          ALUctr  = w_rctr;
        end
        S_RWB: begin
          RegDst = 1'b1; RegWr = 1'b1; instr_done = 1'b1;
        end
        S_EXEC_I: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
          ALUctr  = (OP == OP_ORI) ? 3'b010 : 3'b000;
          ExtOp   = (OP != OP_ORI);
        end
        S_IWB: begin
          RegWr = 1'b1; instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          ALUsrcA = 1'b1; ALUsrcB = 2'b10; ExtOp = 1'b1;
        end
        S_MEM_RD: begin
          IorD = 1'b1; MemRd = 1'b1; mem_err = w_abort;
        end
        S_LWB: begin
          RegWr = 1'b1; MemtoReg = 1'b1; instr_done = 1'b1;
        end
        S_MEM_WR: begin
          IorD = 1'b1; MemWr = 1'b1;
          instr_done = mem_ready && !w_abort;
          mem_err    = w_abort;
        end
        S_BRANCH: begin
          ALUsrcA = 1'b1; ALUctr = 3'b100; PCSrc = 2'b01;
          PCWr = Zero; instr_done = 1'b1;
        end
        S_JUMP: begin
          PCSrc = 2'b10; PCWr = 1'b1; instr_done = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
